// File: rtl/load_store_unit.sv
// Load/store initiator for a word-addressed, byte-enabled data memory with same-cycle read data.
// Define MISALIGNED_SPLIT_EN to split word-crossing accesses into two memory cycles; otherwise they fault.
module load_store_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [14:0] mem_address,
    output logic [3:0]  mem_byteena,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    input  logic [31:0] mem_q,
    output logic [1:0]  state_dbg
);
    // Handshake: a transfer happens on a posedge where valid && ready; valid never waits on ready,
    // and rsp_valid with its payload holds steady until rsp_ready is seen.
    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t      state, state_n;
    logic        write_q, fault_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [14:0] word_q;
    logic [31:0] wdata_q, lo_q, addr_pad, data_hold;
    logic [14:0] addr_hold;
    logic        cross_in, fault_in;
    logic [7:0]  n_mask, m8;
    logic [63:0] w64, data64, shifted;
`ifdef MISALIGNED_SPLIT_EN
    logic        cross_q;
    logic [31:0] hi_q;
`endif

    assign cross_in = (req_funct3[1:0] == 2'd1 && req_address[1:0] == 2'd3) ||
                      (req_funct3[1:0] == 2'd2 && req_address[1:0] != 2'd0);
`ifdef MISALIGNED_SPLIT_EN
    assign fault_in = (req_funct3[1:0] == 2'd3) || (req_write && req_funct3[2]);
`else
    assign fault_in = (req_funct3[1:0] == 2'd3) || (req_write && req_funct3[2]) || cross_in;
`endif

    always_comb begin
        n_mask = 8'b0000_0000;
        case (funct3_q[1:0])
            2'd0:    n_mask = 8'b0000_0001;
            2'd1:    n_mask = 8'b0000_0011;
            2'd2:    n_mask = 8'b0000_1111;
            default: n_mask = 8'b0000_0000;
        endcase
    end

    assign m8  = n_mask << off_q;
    assign w64 = {32'd0, wdata_q} << {off_q, 3'b000};

    always_comb begin
        state_n     = state;
        mem_address = addr_hold;
        mem_data    = data_hold;
        mem_byteena = 4'b0000;
        mem_wren    = 1'b0;
        case (state)
            IDLE: if (req_valid) state_n = fault_in ? RESP : ACC1;
            ACC1: begin
                mem_address = word_q;
                mem_byteena = m8[3:0];
                mem_data    = w64[31:0];
                mem_wren    = write_q;
`ifdef MISALIGNED_SPLIT_EN
                state_n     = cross_q ? ACC2 : RESP;
`else
                state_n     = RESP;
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            ACC2: begin
                mem_address = word_q + 15'd1;  // wraps 0x7FFF -> 0x0000
                mem_byteena = m8[7:4];
                mem_data    = w64[63:32];
                mem_wren    = write_q;
                state_n     = RESP;
            end
`endif
            RESP: if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            write_q   <= 1'b0;
            fault_q   <= 1'b0;
            funct3_q  <= 3'd0;
            off_q     <= 2'd0;
            word_q    <= 15'd0;
            wdata_q   <= 32'd0;
            lo_q      <= 32'd0;
            addr_hold <= 15'd0;
            data_hold <= 32'd0;
`ifdef MISALIGNED_SPLIT_EN
            cross_q   <= 1'b0;
            hi_q      <= 32'd0;
`endif
        end else begin
            state     <= state_n;
            addr_hold <= mem_address;
            data_hold <= mem_data;
            if (state == IDLE && req_valid) begin
                write_q  <= req_write;
                fault_q  <= fault_in;
                funct3_q <= req_funct3;
                off_q    <= req_address[1:0];
                word_q   <= req_address[16:2];
                wdata_q  <= req_wdata;
                lo_q     <= 32'd0;
`ifdef MISALIGNED_SPLIT_EN
                cross_q  <= cross_in;
                hi_q     <= 32'd0;
`endif
            end
            if (state == ACC1) lo_q <= mem_q;
`ifdef MISALIGNED_SPLIT_EN
            if (state == ACC2) hi_q <= mem_q;
`endif
        end
    end

`ifdef MISALIGNED_SPLIT_EN
    assign data64 = {hi_q, lo_q};
`else
    assign data64 = {32'd0, lo_q};
`endif
    assign shifted = data64 >> {off_q, 3'b000};

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_fault = rsp_valid && fault_q;
    assign state_dbg = state;

    always_comb begin
        rsp_rdata = 32'd0;
        if (rsp_valid && !fault_q && !write_q) begin
            case (funct3_q[1:0])
                2'd0:    rsp_rdata = {{24{!funct3_q[2] && shifted[7]}}, shifted[7:0]};
                2'd1:    rsp_rdata = {{16{!funct3_q[2] && shifted[15]}}, shifted[15:0]};
                default: rsp_rdata = shifted[31:0];
            endcase
        end
    end

    logic unused_bits;
    assign addr_pad    = req_address;
    assign unused_bits = ^{addr_pad[31:17], shifted[63:32]};
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural byte-enabled memory.
// Split-access expectations are selected by MISALIGNED_SPLIT_EN, matching the design build.
module tb_load_store_unit;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_address = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [14:0] mem_address;
  logic [3:0]  mem_byteena;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;
  logic [1:0]  state_dbg;

  logic [31:0] mem [0:32767];
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int wr_count = 0;
  int wr_before;

  load_store_unit dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign mem_q = mem[mem_address];
  always @(posedge clock) begin
    if (mem_wren) begin
      wr_count <= wr_count + 1;
      for (int b = 0; b < 4; b++)
        if (mem_byteena[b]) mem[mem_address][8*b +: 8] <= mem_data[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // driver: present one request for one cycle; returns at the negedge of cycle t+1
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_address = a; req_wdata = d;
    acc_cyc = cyc;
    check("req_ready_at_accept", {31'd0, req_ready}, 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // wait (bounded) for the response, check latency and payload, hold it, then consume
  task automatic await_rsp(input string tag, input int lat, input logic flt, input logic [31:0] rd,
                           input int hold);
    logic [31:0] exp;
    exp_q.push_back(rd);
    while (!rsp_valid && (cyc - acc_cyc) < 8) @(negedge clock);
    check({tag, "_latency"}, cyc - acc_cyc, lat);
    check({tag, "_fault"}, {31'd0, rsp_fault}, {31'd0, flt});
    exp = exp_q.pop_front();
    check({tag, "_rdata"}, rsp_rdata, exp);
    check({tag, "_resp_wren"}, {31'd0, mem_wren}, 32'd0);
    repeat (hold) begin
      @(negedge clock);
      check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_hold_rdata"}, rsp_rdata, exp);
      check({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check({tag, "_consumed"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_fault"}, {31'd0, rsp_fault}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_mem_wren"}, {31'd0, mem_wren}, 32'd0);
    check({tag, "_byteena"}, {28'd0, mem_byteena}, 32'd0);
    check({tag, "_mem_address"}, {17'd0, mem_address}, 32'd0);
    check({tag, "_mem_data"}, mem_data, 32'd0);
    check({tag, "_state"}, {30'd0, state_dbg}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check_reset_values("reset");
    reset_n = 1'b1;

    // store byte 0xA5 at 0x102
    mem[15'h40] = 32'h1122_3344;
    issue(1'b1, 3'd0, 32'h0000_0102, 32'h0000_00A5);
    check("sb_acc1_addr", {17'd0, mem_address}, 32'h40);
    check("sb_acc1_be", {28'd0, mem_byteena}, 32'b0100);
    check("sb_acc1_data", mem_data, 32'h00A5_0000);
    check("sb_acc1_wren", {31'd0, mem_wren}, 32'd1);
    @(negedge clock);
    check("sb_hold_addr", {17'd0, mem_address}, 32'h40);
    check("sb_hold_data", mem_data, 32'h00A5_0000);
    check("sb_hold_be", {28'd0, mem_byteena}, 32'd0);
    await_rsp("sb", 2, 1'b0, 32'd0, 0);
    check("sb_mem", mem[15'h40], 32'h11A5_3344);

    // loads from word 0x80FF_1234
    mem[15'h40] = 32'h80FF_1234;
    issue(1'b0, 3'd1, 32'h0000_0102, 32'd0); await_rsp("lh_102", 2, 1'b0, 32'hFFFF_80FF, 0);
    issue(1'b0, 3'd5, 32'h0000_0102, 32'd0); await_rsp("lhu_102", 2, 1'b0, 32'h0000_80FF, 0);
    issue(1'b0, 3'd0, 32'h0000_0103, 32'd0); await_rsp("lb_103", 2, 1'b0, 32'hFFFF_FF80, 0);
    issue(1'b0, 3'd4, 32'h0000_0103, 32'd0); await_rsp("lbu_103", 2, 1'b0, 32'h0000_0080, 0);
    issue(1'b0, 3'd0, 32'h0000_0100, 32'd0); await_rsp("lb_100", 2, 1'b0, 32'h0000_0034, 0);
    issue(1'b0, 3'd2, 32'h0000_0100, 32'd0); await_rsp("lw_100", 2, 1'b0, 32'h80FF_1234, 0);
    issue(1'b0, 3'd1, 32'h0000_0101, 32'd0); await_rsp("lh_101", 2, 1'b0, 32'hFFFF_FF12, 0);
    issue(1'b0, 3'd5, 32'h0000_0101, 32'd0); await_rsp("lhu_101", 2, 1'b0, 32'h0000_FF12, 0);

    // illegal requests fault with no memory cycle
    wr_before = wr_count;
    issue(1'b1, 3'd3, 32'h0000_0100, 32'hFFFF_FFFF);
    check("f3_3_wren", {31'd0, mem_wren}, 32'd0);
    await_rsp("f3_3", 1, 1'b1, 32'd0, 0);
    issue(1'b1, 3'd4, 32'h0000_0100, 32'hFFFF_FFFF); await_rsp("st_uns", 1, 1'b1, 32'd0, 0);
    check("fault_no_write", wr_count, wr_before);
    check("fault_mem", mem[15'h40], 32'h80FF_1234);

    // backpressure
    issue(1'b0, 3'd1, 32'h0000_0102, 32'd0); await_rsp("bp", 2, 1'b0, 32'hFFFF_80FF, 5);

    // word-crossing store and wrapping load
    mem[15'h41] = 32'h9999_9999;
    mem[15'h7FFF] = 32'h1122_3344;
    mem[15'h0000] = 32'h5566_7788;
    wr_before = wr_count;
`ifdef MISALIGNED_SPLIT_EN
    issue(1'b1, 3'd2, 32'h0000_0103, 32'hDDCC_BBAA);
    check("sw_acc1_addr", {17'd0, mem_address}, 32'h40);
    check("sw_acc1_be", {28'd0, mem_byteena}, 32'b1000);
    check("sw_acc1_data", mem_data, 32'hAA00_0000);
    @(negedge clock);
    check("sw_acc2_addr", {17'd0, mem_address}, 32'h41);
    check("sw_acc2_be", {28'd0, mem_byteena}, 32'b0111);
    check("sw_acc2_data", mem_data, 32'h00DD_CCBB);
    check("sw_acc2_wren", {31'd0, mem_wren}, 32'd1);
    await_rsp("sw_split", 3, 1'b0, 32'd0, 0);
    check("sw_mem40", mem[15'h40], 32'hAAFF_1234);
    check("sw_mem41", mem[15'h41], 32'h99DD_CCBB);
    check("sw_writes", wr_count - wr_before, 2);

    issue(1'b0, 3'd2, 32'h0001_FFFE, 32'd0);
    check("lw_wrap_acc1_addr", {17'd0, mem_address}, 32'h7FFF);
    check("lw_wrap_acc1_be", {28'd0, mem_byteena}, 32'b1100);
    @(negedge clock);
    check("lw_wrap_acc2_addr", {17'd0, mem_address}, 32'h0000);
    check("lw_wrap_acc2_be", {28'd0, mem_byteena}, 32'b0011);
    await_rsp("lw_wrap", 3, 1'b0, 32'h7788_1122, 0);

    // reset during ACC2 of a split store: only the ACC1 byte lands
    mem[15'h40] = 32'd0;
    mem[15'h41] = 32'd0;
    issue(1'b1, 3'd2, 32'h0000_0103, 32'hDDCC_BBAA);
    @(negedge clock);
    check("rst_in_acc2", {30'd0, state_dbg}, 32'd2);
    reset_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    @(negedge clock);
    reset_n = 1'b1;
    check("rst_mem40", mem[15'h40], 32'hAA00_0000);
    check("rst_mem41", mem[15'h41], 32'h0000_0000);
`else
    issue(1'b1, 3'd2, 32'h0000_0103, 32'hDDCC_BBAA);
    check("sw_cross_wren", {31'd0, mem_wren}, 32'd0);
    await_rsp("sw_cross", 1, 1'b1, 32'd0, 0);
    issue(1'b0, 3'd1, 32'h0000_0103, 32'd0); await_rsp("lh_cross", 1, 1'b1, 32'd0, 0);
    issue(1'b0, 3'd2, 32'h0001_FFFE, 32'd0); await_rsp("lw_wrap_cross", 1, 1'b1, 32'd0, 0);
    check("cross_no_write", wr_count, wr_before);
    check("cross_mem40", mem[15'h40], 32'h80FF_1234);
    check("cross_mem41", mem[15'h41], 32'h9999_9999);

    // reset during ACC1 of a load
    issue(1'b0, 3'd2, 32'h0000_0100, 32'd0);
    check("rst_in_acc1", {30'd0, state_dbg}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    @(negedge clock);
    reset_n = 1'b1;
    mem[15'h40] = 32'hAA00_0000;
`endif

    // recovery after reset
    issue(1'b0, 3'd2, 32'h0000_0100, 32'd0); await_rsp("lw_after_rst", 2, 1'b0, 32'hAA00_0000, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port. Accepts one load/store request at a time from the core pipeline and drives the word-addressed, byte-enabled data memory (15-bit word address, 4-bit byte enable, 32-bit data, write enable, same-cycle read data). It generates byte enables, lane-shifts store data, and extracts and sign- or zero-extends load data. Accesses crossing a word boundary are split into two memory cycles when configured; otherwise they fault.

## Interface
- No parameters; memory geometry is fixed at 2^15 words of 32 bits.
- clock  in  1  sole clock; all state changes on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high exactly in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width code: [1:0] size (0 = byte, 1 = half, 2 = word, 3 = illegal); [2] = unsigned load.
- req_address  in  32  byte address; only [16:0] used.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  core consumes response.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- rsp_fault  out  1  request rejected; no memory write occurred.
- mem_address  out  15  word address to memory.
- mem_byteena  out  4  byte enables.
- mem_data  out  32  lane-aligned write data.
- mem_wren  out  1  write strobe.
- mem_q  in  32  read data for mem_address in the same cycle (combinational).

## Operation
- States: IDLE, ACC1, ACC2, RESP.
- IDLE: req_ready=1. On req_valid, latch the request: off=addr[1:0], n=1/2/4, word=addr[16:2].
- Fault if size=3, or if req_write is set together with funct3[2], or if the access crosses a word boundary (off+n>4) and MISALIGNED_SPLIT_EN is undefined. A faulting request goes IDLE→RESP with rsp_fault=1 and no memory cycle.
- Otherwise IDLE→ACC1.
- Lane mask: m8=((1<<n)-1)<<off, 8 bits. Shifted data: w64=zext(wdata)<<(8*off).
- ACC1: mem_address=word, mem_byteena=m8[3:0], mem_data=w64[31:0], mem_wren=req_write. Capture mem_q into lo. If crossing, go to ACC2; else go to RESP.
- ACC2: mem_address=word+1, wrapping 0x7FFF→0x0000. mem_byteena=m8[7:4], mem_data=w64[63:32], mem_wren=req_write. Capture mem_q into hi. Go to RESP.
- Load result: r={hi,lo}>>(8*off), truncated to n bytes. Sign-extend when funct3[2]=0, zero-extend when funct3[2]=1. Word loads ignore funct3[2].
- RESP: rsp_valid=1, outputs stable. When rsp_ready=1, go to IDLE.
- Outside ACC states: mem_wren=0, mem_byteena=0; mem_address and mem_data hold their last values.
- A request is never accepted in the same cycle a response is consumed.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_fault=0, rsp_rdata=0, mem_wren=0, mem_byteena=0, mem_address=0, mem_data=0.
- Accept in cycle t. Then:
  - aligned access: ACC1 at t+1, rsp_valid from t+2;
  - split access: rsp_valid from t+3;
  - fault: rsp_valid from t+1.
- rsp_ready held high gives a throughput of one request per 3 cycles (aligned); the next accept happens at the earliest in the cycle after the response is consumed.
- Reset asserted mid-operation: immediate return to reset values and the pending response is dropped. A split store may already have committed its ACC1 half; it is not rolled back.

## Configuration
- MISALIGNED_SPLIT_EN defined: word-crossing accesses take two memory cycles as above. The ACC2 state and the hi register exist.
- MISALIGNED_SPLIT_EN undefined: ACC2 and hi are removed. Any request with off+n>4 faults with zero memory writes.
- Both builds:
  - within-word unaligned halves (off=1) are legal single accesses;
  - the illegal-funct3 fault is unaffected.

## Test plan
- Store byte 0xA5 at 0x0000_0102 (funct3=0) → one ACC1 with mem_address=0x0040, byteena=0100, mem_data[23:16]=0xA5; rsp_valid at t+2, rsp_rdata=0.
- Memory word 0x40 = 0x80FF_1234; load half at 0x102, funct3=1 → 0xFFFF_80FF; the same load with funct3=5 → 0x0000_80FF.
- Split build, store word 0xDDCCBBAA at 0x103 → ACC1: addr 0x40, byteena 1000, data 0xAA00_0000; ACC2: addr 0x41, byteena 0111, data 0x00DD_CCBB; rsp_valid at t+3.
- Split build, load word at 0x1_FFFE with word 0x7FFF=0x1122_3344 and word 0x0000=0x5566_7788 → ACC2 address wraps to 0; rsp_rdata=0x7788_1122.
- Non-split build, the same store at 0x103 → mem_wren never asserted; rsp_fault=1 at t+1. Any build, funct3=3 → fault.
- Backpressure: rsp_ready held low for 5 cycles → rsp_valid and rsp_rdata stable and req_ready=0 throughout. Asserting reset_n=0 during ACC2 of a split store → outputs return to reset values immediately; only the ACC1 bytes are written.
